// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipe: load-use stalls, branch flushes, memory waits.
// Define PERF_CNT_EN to add saturating stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_W           = 5,
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MAXC = (LU_STALL_CYCLES > FLUSH_CYCLES) ?
                        LU_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } st_e;

  st_e           st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lu;
  logic          lu_bub;

  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign state = st;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    lu_bub      = 1'b0;
    st_nx       = st;
    cnt_nx      = cnt;
    if (mem_busy) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      pipe_hold = 1'b1;
      st_nx     = MEM_WAIT;
      cnt_nx    = '0;
    end else if (branch_taken) begin
      // A taken branch also abandons any load-use stall in progress
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        st_nx  = FLUSH;
        cnt_nx = CW'(FLUSH_CYCLES - 1);
      end else begin
        st_nx  = RUN;
        cnt_nx = '0;
      end
    end else begin
      unique case (st)
        LU_STALL: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          lu_bub      = 1'b1;
          if (cnt == CW'(1)) begin
            st_nx  = RUN;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt == CW'(1)) begin
            st_nx  = RUN;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        default: begin
          // RUN, and MEM_WAIT once memory is ready again
          st_nx  = RUN;
          cnt_nx = '0;
          if (lu) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            lu_bub      = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              st_nx  = LU_STALL;
              cnt_nx = CW'(LU_STALL_CYCLES - 1);
            end
          end
        end
      endcase
    end
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
      lu_bub      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_bub && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = lu_bub;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two parameter sets (plus a narrow-counter
// instance when PERF_CNT_EN is defined) driven by shared stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;

  logic       a_pc_we, a_ifid_we, a_flush, a_bub, a_hold;
  logic [1:0] a_state;
  logic       b_pc_we, b_ifid_we, b_flush, b_bub, b_hold;
  logic [1:0] b_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef PERF_CNT_EN
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
  logic [1:0]  c_stall_cnt, c_flush_cnt;
  logic        c_pc_we, c_ifid_we, c_flush, c_bub, c_hold;
  logic [1:0]  c_state;
`endif

  pipe_hazard_ctrl #(
    .REG_W(5), .LU_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_flush),
    .idex_bubble(a_bub), .pipe_hold(a_hold), .state(a_state)
`ifdef PERF_CNT_EN
    , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
  );

  pipe_hazard_ctrl #(
    .REG_W(5), .LU_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_flush),
    .idex_bubble(b_bub), .pipe_hold(b_hold), .state(b_state)
`ifdef PERF_CNT_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

`ifdef PERF_CNT_EN
  pipe_hazard_ctrl #(
    .REG_W(5), .LU_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2)
  ) u_c (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(c_pc_we), .ifid_we(c_ifid_we), .ifid_flush(c_flush),
    .idex_bubble(c_bub), .pipe_hold(c_hold), .state(c_state),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst          = 1'b0;
    id_rs        = '0;
    id_rt        = '0;
    ex_rt        = '0;
    id_uses_rt   = 1'b0;
    ex_mem_read  = 1'b0;
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    idle();
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd5;
    id_rs       = 5'd5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    // reset dominates busy and branch
    rst = 1'b1; mem_busy = 1'b1; branch_taken = 1'b1;
    step(); #2;
    check("rst_pc_we", a_pc_we, 0);
    check("rst_ifid_we", a_ifid_we, 0);
    check("rst_flush", a_flush, 1);
    check("rst_bubble", a_bub, 1);
    check("rst_hold", a_hold, 0);
    check("rst_state", a_state, 0);
    step(); #2;
    check("rst2_state_b", b_state, 0);
    check("rst2_pc_we_b", b_pc_we, 0);
    idle(); #2;
    check("idle_pc_we", a_pc_we, 1);
    check("idle_flush", a_flush, 0);
    check("idle_bubble", a_bub, 0);
    step(); #2;
    check("idle_state", a_state, 0);

    // load-use, single bubble
    set_lu(); #2;
    check("lu_pc_we", a_pc_we, 0);
    check("lu_ifid_we", a_ifid_we, 0);
    check("lu_bubble", a_bub, 1);
    check("lu_flush", a_flush, 0);
    step(); idle(); #2;
    check("lu_after_pc_we", a_pc_we, 1);
    check("lu_after_bubble", a_bub, 0);
    check("lu_after_state", a_state, 0);

    // register 0 and Rt gating
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #2;
    check("r0_bubble", a_bub, 0);
    check("r0_pc_we", a_pc_we, 1);
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0; #2;
    check("rt_unused_bubble", a_bub, 0);
    id_uses_rt = 1'b1; #2;
    check("rt_used_bubble", a_bub, 1);
    check("rt_used_pc_we", a_pc_we, 0);
    check("rt_used_bubble_b", b_bub, 1);
    // three-bubble stall continues after the hazard disappears
    step(); idle(); #2;
    check("lus_state1", b_state, 1);
    check("lus_bubble1", b_bub, 1);
    check("lus_pc_we1", b_pc_we, 0);
    check("lus_a_bubble", a_bub, 0);
    step(); #2;
    check("lus_state2", b_state, 1);
    check("lus_bubble2", b_bub, 1);
    step(); #2;
    check("lus_state3", b_state, 0);
    check("lus_bubble3", b_bub, 0);
    check("lus_pc_we3", b_pc_we, 1);

    // branch and load-use together, two-cycle flush
    do_reset();
    branch_taken = 1'b1; set_lu(); #2;
    check("br_flush_b", b_flush, 1);
    check("br_pc_we_b", b_pc_we, 1);
    check("br_bubble_b", b_bub, 1);
    check("br_flush_a", a_flush, 1);
    check("br_pc_we_a", a_pc_we, 1);
    step(); branch_taken = 1'b0; #2;
    check("br2_state_b", b_state, 2);
    check("br2_flush_b", b_flush, 1);
    check("br2_pc_we_b", b_pc_we, 1);
    check("br2_state_a", a_state, 0);
    check("br2_lu_pc_we_a", a_pc_we, 0);
    step(); idle(); #2;
    check("br3_state_b", b_state, 0);
    check("br3_flush_b", b_flush, 0);

    // memory wait during a load-use stall, hazard still present
    do_reset();
    set_lu(); #2;
    check("mw_bubble0", b_bub, 1);
    step(); mem_busy = 1'b1; #2;
    check("mw_state_pre", b_state, 1);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("mw_hold", b_hold, 1);
      check("mw_pc_we", b_pc_we, 0);
      check("mw_bubble", b_bub, 0);
      step();
      check("mw_state", b_state, 3);
    end
    mem_busy = 1'b0; #2;
    check("mw_rel_hold", b_hold, 0);
    check("mw_rel_bubble", b_bub, 1);
    check("mw_rel_pc_we", b_pc_we, 0);
    step(); #2;
    check("mw_rel_state", b_state, 1);

    // memory wait with the hazard gone: no re-raised stall
    do_reset();
    set_lu();
    step(); mem_busy = 1'b1; ex_mem_read = 1'b0;
    step(); mem_busy = 1'b0; #2;
    check("mw2_bubble", b_bub, 0);
    check("mw2_pc_we", b_pc_we, 1);
    step(); #2;
    check("mw2_state", b_state, 0);

`ifdef PERF_CNT_EN
    do_reset(); #2;
    check("pc_rst_stall", a_stall_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      set_lu(); step(); idle(); step();
    end
    for (int i = 0; i < 2; i++) begin
      branch_taken = 1'b1; step(); idle(); step();
    end
    #2;
    check("pc_stall_a", a_stall_cnt, 4);
    check("pc_flush_a", a_flush_cnt, 2);
    check("pc_stall_c", c_stall_cnt, 3);
    check("pc_flush_c", c_flush_cnt, 2);
    set_lu(); step(); idle(); #2;
    check("pc_stall5_a", a_stall_cnt, 5);
    check("pc_stall5_c", c_stall_cnt, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
